// File: rtl/spi_bootload_pkg.sv
// Shared encodings for the spi_bootload command sequencer: opcodes,
// spi_bootload register addresses and sequencer FSM state codes.
package spi_bootload_pkg;

    // High-level flash operations accepted on op_i (5..7 are illegal)
    localparam logic [2:0] OP_ID     = 3'd0;
    localparam logic [2:0] OP_ERASE  = 3'd1;
    localparam logic [2:0] OP_PROG   = 3'd2;
    localparam logic [2:0] OP_READ   = 3'd3;
    localparam logic [2:0] OP_REBOOT = 3'd4;

    // spi_bootload register map
    localparam logic [1:0] REG_FIFO  = 2'd0;
    localparam logic [1:0] REG_ADRLO = 2'd1;
    localparam logic [1:0] REG_ADRHI = 2'd2;
    localparam logic [1:0] REG_CMD   = 2'd3;

    // Sequencer states
    typedef logic [3:0] state_t;
    localparam state_t S_IDLE   = 4'd0;
    localparam state_t S_FRST   = 4'd1;
    localparam state_t S_FILL   = 4'd2;
    localparam state_t S_WA1    = 4'd3;
    localparam state_t S_WA2    = 4'd4;
    localparam state_t S_WCMD   = 4'd5;
    localparam state_t S_RSTAT  = 4'd6;
    localparam state_t S_RID_LO = 4'd7;
    localparam state_t S_RID_HI = 4'd8;
    localparam state_t S_DRAIN  = 4'd9;
    localparam state_t S_ULOCK  = 4'd10;
    localparam state_t S_DONE   = 4'd11;

endpackage

// File: rtl/spi_bootload_access.sv
// Single-access engine for the spi_bootload port. A write occupies exactly
// the request cycle. A read pulses bl_en_o once, then waits for bl_valid_i
// or the timeout; while it waits, further requests are held off so bl_en_o
// can never fire with a read outstanding. The requester may therefore keep
// req_i high for the whole of a read state.
module spi_bootload_access #(
    parameter int unsigned TIMEOUT = 2000000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_i,
    input  logic        wr_i,
    input  logic [1:0]  adr_i,
    input  logic [15:0] dat_i,
    output logic        ack_o,
    output logic        timeout_o,
    output logic [15:0] rdata_o,
    output logic [1:0]  bl_adr_o,
    output logic [15:0] bl_dat_o,
    output logic        bl_en_o,
    output logic        bl_wr_o,
    input  logic [15:0] bl_dat_i,
    input  logic        bl_valid_i
);

    logic        wait_q, wait_d;
    logic [31:0] cnt_q, cnt_d;
    logic        issue;

    assign issue     = req_i & ~wait_q;
    assign bl_en_o   = issue;
    assign bl_wr_o   = issue & wr_i;
    assign bl_adr_o  = issue ? adr_i : 2'd0;
    assign bl_dat_o  = (issue & wr_i) ? dat_i : 16'd0;
    assign ack_o     = (issue & wr_i) | (wait_q & bl_valid_i);
    // cnt_q counts cycles since the en pulse; a late valid still wins
    assign timeout_o = wait_q & ~bl_valid_i & (cnt_q >= TIMEOUT);
    assign rdata_o   = bl_dat_i;

    // Read-wait tracking and timeout counting
    always_comb begin
        wait_d = wait_q;
        cnt_d  = cnt_q;
        if (issue && !wr_i) begin
            wait_d = 1'b1;
            cnt_d  = 32'd1;
        end else if (wait_q) begin
            if (bl_valid_i || timeout_o) begin
                wait_d = 1'b0;
                cnt_d  = 32'd0;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wait_q <= 1'b0;
            cnt_q  <= 32'd0;
        end else begin
            wait_q <= wait_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_bootload_seq.sv
// Command sequencer in front of spi_bootload: turns one high-level flash
// op into the register write/read sequence, streams page data in (PROG)
// and out (READ), and reports status word, IDCODE and errors.
module spi_bootload_seq #(
    parameter int          PAGE_WORDS = 256,
    parameter logic [15:0] CMD_ID     = 16'h9E9E,
    parameter logic [15:0] CMD_PROG   = 16'h0302,
    parameter logic [15:0] CMD_READ   = 16'h0203,
    parameter logic [15:0] CMD_ERASE  = 16'hDEDE,
    parameter logic [15:0] CMD_UNLOCK = 16'h93FE,
    parameter logic [15:0] CMD_REBOOT = 16'hFFFF,
    parameter logic [31:0] UNLOCK_KEY = 32'h42796533,
    parameter logic [15:0] FIFO_RST   = 16'h8000,
    parameter int unsigned TIMEOUT    = 2000000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] addr_i,
    input  logic        op_valid_i,
    output logic        op_ready_o,
    input  logic [15:0] wdat_i,
    input  logic        wdat_valid_i,
    output logic        wdat_ready_o,
    output logic [15:0] rdat_o,
    output logic        rdat_valid_o,
    input  logic        rdat_ready_i,
    output logic        done_o,
    output logic        err_o,
    output logic [15:0] status_o,
    output logic [31:0] id_o,
    output logic [1:0]  bl_adr_o,
    output logic [15:0] bl_dat_o,
    output logic        bl_en_o,
    output logic        bl_wr_o,
    input  logic [15:0] bl_dat_i,
    input  logic        bl_valid_i
);
    import spi_bootload_pkg::*;

    localparam logic [8:0] LAST_WORD = 9'(PAGE_WORDS - 1);
    localparam logic [8:0] FULL_CNT  = 9'(PAGE_WORDS);

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic        reb_q, reb_d;        // REBOOT: 0 = unlock half, 1 = reboot half
    logic [8:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [15:0] status_q, status_d;
    logic [31:0] id_q, id_d;
    logic [15:0] rdat_q, rdat_d;
    logic        rdat_valid_q, rdat_valid_d;

    logic        req, wr, ack, acc_timeout;
    logic [1:0]  adr;
    logic [15:0] dat, rdata;
    logic [15:0] lo_val, hi_val, cmd_val;
    logic [8:0]  cnt_inc;

    spi_bootload_access #(.TIMEOUT(TIMEOUT)) u_access (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .req_i      (req),
        .wr_i       (wr),
        .adr_i      (adr),
        .dat_i      (dat),
        .ack_o      (ack),
        .timeout_o  (acc_timeout),
        .rdata_o    (rdata),
        .bl_adr_o   (bl_adr_o),
        .bl_dat_o   (bl_dat_o),
        .bl_en_o    (bl_en_o),
        .bl_wr_o    (bl_wr_o),
        .bl_dat_i   (bl_dat_i),
        .bl_valid_i (bl_valid_i)
    );

    assign op_ready_o   = (state_q == S_IDLE);
    assign wdat_ready_o = (state_q == S_FILL) & wdat_valid_i;
    assign done_o       = (state_q == S_DONE);
    assign err_o        = done_o & err_q;
    assign status_o     = status_q;
    assign id_o         = id_q;
    assign rdat_o       = rdat_q;
    assign rdat_valid_o = rdat_valid_q;
    // word counter saturates at a full page instead of wrapping
    assign cnt_inc      = (cnt_q == FULL_CNT) ? cnt_q : cnt_q + 9'd1;

    // Values for the address-lo / address-hi / command writes of the current op
    always_comb begin
        lo_val  = addr_q[15:0];
        hi_val  = addr_q[31:16];
        cmd_val = CMD_ERASE;
        case (op_q)
            OP_ID: begin
                lo_val  = 16'd0;
                hi_val  = 16'd0;
                cmd_val = CMD_ID;
            end
            OP_PROG: cmd_val = CMD_PROG;
            OP_READ: cmd_val = CMD_READ;
            OP_REBOOT: begin
                if (!reb_q) begin
                    lo_val  = UNLOCK_KEY[15:0];
                    hi_val  = UNLOCK_KEY[31:16];
                    cmd_val = CMD_UNLOCK;
                end else begin
                    lo_val  = 16'd0;
                    hi_val  = 16'd0;
                    cmd_val = CMD_REBOOT;
                end
            end
            default: ;
        endcase
    end

    // Sequencer next-state and access requests
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        reb_d        = reb_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        status_d     = status_q;
        id_d         = id_q;
        rdat_d       = rdat_q;
        rdat_valid_d = rdat_valid_q;
        req          = 1'b0;
        wr           = 1'b0;
        adr          = REG_FIFO;
        dat          = 16'd0;
        case (state_q)
            S_IDLE: begin
                if (op_valid_i) begin
                    op_d   = op_i;
                    addr_d = addr_i;
                    reb_d  = 1'b0;
                    cnt_d  = 9'd0;
                    err_d  = 1'b0;
                    case (op_i)
                        OP_ID, OP_ERASE, OP_REBOOT: state_d = S_WA1;
                        OP_PROG, OP_READ:           state_d = S_FRST;
                        default: begin
                            err_d   = 1'b1;
                            state_d = S_DONE;
                        end
                    endcase
                end
            end
            S_FRST: begin
                req = 1'b1;
                wr  = 1'b1;
                dat = FIFO_RST;
                if (ack) state_d = (op_q == OP_PROG) ? S_FILL : S_WA1;
            end
            S_FILL: begin
                // a gap in wdat_valid_i simply stalls here; no timeout applies
                req = wdat_valid_i;
                wr  = 1'b1;
                dat = wdat_i;
                if (ack) begin
                    cnt_d = cnt_inc;
                    if (cnt_q == LAST_WORD) state_d = S_WA1;
                end
            end
            S_WA1: begin
                req = 1'b1;
                wr  = 1'b1;
                adr = REG_ADRLO;
                dat = lo_val;
                if (ack) state_d = S_WA2;
            end
            S_WA2: begin
                req = 1'b1;
                wr  = 1'b1;
                adr = REG_ADRHI;
                dat = hi_val;
                if (ack) state_d = S_WCMD;
            end
            S_WCMD: begin
                req = 1'b1;
                wr  = 1'b1;
                adr = REG_CMD;
                dat = cmd_val;
                if (ack) state_d = S_RSTAT;
            end
            S_RSTAT: begin
                req = 1'b1;
                adr = REG_CMD;
                if (acc_timeout) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (ack) begin
                    status_d = rdata;
                    case (op_q)
                        OP_ID:     state_d = S_RID_LO;
                        OP_READ: begin
                            cnt_d   = 9'd0;
                            state_d = S_DRAIN;
                        end
                        OP_REBOOT: state_d = reb_q ? S_DONE : S_ULOCK;
                        default:   state_d = S_DONE;
                    endcase
                end
            end
            S_RID_LO: begin
                req = 1'b1;
                adr = REG_ADRLO;
                if (acc_timeout) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (ack) begin
                    id_d[15:0] = rdata;
                    state_d    = S_RID_HI;
                end
            end
            S_RID_HI: begin
                req = 1'b1;
                adr = REG_ADRHI;
                if (acc_timeout) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (ack) begin
                    id_d[31:16] = rdata;
                    state_d     = S_DONE;
                end
            end
            S_DRAIN: begin
                // one FIFO read at a time; the next is issued only after the
                // previous word has been handed off on rdat_o
                if (rdat_valid_q) begin
                    if (rdat_ready_i) begin
                        rdat_valid_d = 1'b0;
                        if (cnt_q == FULL_CNT) state_d = S_DONE;
                    end
                end else begin
                    req = 1'b1;
                    adr = REG_FIFO;
                    if (acc_timeout) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (ack) begin
                        rdat_d       = rdata;
                        rdat_valid_d = 1'b1;
                        cnt_d        = cnt_inc;
                    end
                end
            end
            S_ULOCK: begin
                reb_d   = 1'b1;
                state_d = S_WA1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer registers; reset abandons any op in flight
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            op_q         <= 3'd0;
            addr_q       <= 32'd0;
            reb_q        <= 1'b0;
            cnt_q        <= 9'd0;
            err_q        <= 1'b0;
            status_q     <= 16'd0;
            id_q         <= 32'd0;
            rdat_q       <= 16'd0;
            rdat_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            reb_q        <= reb_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            status_q     <= status_d;
            id_q         <= id_d;
            rdat_q       <= rdat_d;
            rdat_valid_q <= rdat_valid_d;
        end
    end

endmodule

// File: tb/tb_spi_bootload_seq.sv
// Scoreboard bench for spi_bootload_seq: a bus model of spi_bootload answers
// the register port, stimulus pushes expected bus accesses / results / read
// words into queues, and negedge monitors pop and compare.
module tb_spi_bootload_seq;
    localparam int PW = 256;
    localparam int TO = 100;
    typedef logic [15:0] page_t [PW];
    typedef struct packed { logic wr; logic [1:0] adr; logic [15:0] dat; } acc_t;
    typedef struct packed { logic err; logic [15:0] status; logic [31:0] id; } res_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [2:0]  op_i = 3'd0;
    logic [31:0] addr_i = 32'd0;
    logic        op_valid_i = 1'b0, op_ready_o;
    logic [15:0] wdat_i = 16'd0;
    logic        wdat_valid_i = 1'b0, wdat_ready_o;
    logic [15:0] rdat_o;
    logic        rdat_valid_o, rdat_ready_i = 1'b0;
    logic        done_o, err_o;
    logic [15:0] status_o;
    logic [31:0] id_o;
    logic [1:0]  bl_adr_o;
    logic [15:0] bl_dat_o;
    logic        bl_en_o, bl_wr_o;
    logic [15:0] bl_dat_i = 16'd0;
    logic        bl_valid_i = 1'b0;

    int errors = 0, checks = 0;
    acc_t        exp_bus[$];
    res_t        exp_res[$];
    logic [15:0] exp_rd[$];
    page_t       ref_flash [logic [31:0]];   // reference: what each page should hold
    logic [31:0] idcode = 32'h1018BA20;
    logic [15:0] stat_val = 16'd0, last_stat = 16'd0;
    logic [31:0] last_id = 32'd0;

    // bus model state
    logic [15:0] r_lo = 16'd0, r_hi = 16'd0, pend_dat = 16'd0;
    logic [15:0] fifo[$];
    page_t       dev_flash [logic [31:0]];
    int          pend = 0;
    logic        drop_next = 1'b0;

    spi_bootload_seq #(.TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .op_i(op_i), .addr_i(addr_i),
        .op_valid_i(op_valid_i), .op_ready_o(op_ready_o),
        .wdat_i(wdat_i), .wdat_valid_i(wdat_valid_i), .wdat_ready_o(wdat_ready_o),
        .rdat_o(rdat_o), .rdat_valid_o(rdat_valid_o), .rdat_ready_i(rdat_ready_i),
        .done_o(done_o), .err_o(err_o), .status_o(status_o), .id_o(id_o),
        .bl_adr_o(bl_adr_o), .bl_dat_o(bl_dat_o), .bl_en_o(bl_en_o), .bl_wr_o(bl_wr_o),
        .bl_dat_i(bl_dat_i), .bl_valid_i(bl_valid_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic void pw(input logic [1:0] a, input logic [15:0] v);
        exp_bus.push_back({1'b1, a, v});
    endfunction
    function automatic void pr(input logic [1:0] a);
        exp_bus.push_back({1'b0, a, 16'h0000});
    endfunction

    // spi_bootload bus model plus bus-trace monitor
    always @(negedge clk) begin
        bl_valid_i = 1'b0;
        if (!rst_n) begin
            pend = 0;
            drop_next = 1'b0;
            fifo.delete();
        end else begin
            if (bl_en_o) begin
                acc_t e;
                check("en_while_read_busy", {pend > 0, rdat_valid_o}, 0);
                if (exp_bus.size() == 0) begin
                    check("unexpected_access", {bl_wr_o, bl_adr_o, bl_dat_o}, 0);
                end else begin
                    e = exp_bus.pop_front();
                    check("bus_access", {bl_wr_o, bl_adr_o, bl_wr_o ? bl_dat_o : 16'h0}, e);
                end
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    bl_valid_i = 1'b1;
                    bl_dat_i = pend_dat;
                end
            end
            if (bl_en_o && bl_wr_o) begin
                case (bl_adr_o)
                    2'd0: if (bl_dat_o == 16'h8000) fifo.delete(); else fifo.push_back(bl_dat_o);
                    2'd1: r_lo = bl_dat_o;
                    2'd2: r_hi = bl_dat_o;
                    default: begin
                        page_t pg;
                        if (bl_dat_o == 16'h9E9E) begin
                            r_lo = idcode[15:0];
                            r_hi = idcode[31:16];
                        end else if (bl_dat_o == 16'h0302) begin
                            for (int i = 0; i < PW; i++)
                                pg[i] = (fifo.size() > 0) ? fifo.pop_front() : 16'hFFFF;
                            dev_flash[{r_hi, r_lo}] = pg;
                        end else if (bl_dat_o == 16'h0203) begin
                            fifo.delete();
                            for (int i = 0; i < PW; i++)
                                fifo.push_back(dev_flash.exists({r_hi, r_lo}) ? dev_flash[{r_hi, r_lo}][i] : 16'hFFFF);
                        end else if (bl_dat_o == 16'hFFFF) begin
                            drop_next = 1'b1;   // device reboots and never answers
                        end
                    end
                endcase
            end else if (bl_en_o) begin
                case (bl_adr_o)
                    2'd0: pend_dat = (fifo.size() > 0) ? fifo.pop_front() : 16'hFFFF;
                    2'd1: pend_dat = r_lo;
                    2'd2: pend_dat = r_hi;
                    default: pend_dat = stat_val;
                endcase
                if (drop_next) drop_next = 1'b0;
                else pend = $urandom_range(1, 4);
            end
        end
    end

    // completion monitor
    always @(negedge clk) begin
        if (rst_n && done_o) begin
            if (exp_res.size() == 0) begin
                check("unexpected_done", done_o, 0);
            end else begin
                res_t r;
                r = exp_res.pop_front();
                check("done_err", err_o, r.err);
                check("status", status_o, r.status);
                check("idcode", id_o, r.id);
            end
        end
    end

    // read-data monitor
    always @(negedge clk) begin
        if (rst_n && rdat_valid_o && rdat_ready_i) begin
            if (exp_rd.size() == 0) check("unexpected_rdat", rdat_o, 0);
            else check("rdat", rdat_o, exp_rd.pop_front());
        end
    end

    // 50% read-side back-pressure
    initial begin
        forever begin
            @(posedge clk);
            #1 rdat_ready_i = 1'($urandom_range(0, 1));
        end
    end

    // op: 0..7; seq: page data 0..N-1 instead of random; stop_at: abandon FILL after that many words
    task automatic run_op(input logic [2:0] op, input logic [31:0] addr, input bit seq, input int stop_at);
        page_t d;
        int n = 0, i = 0;
        logic rd;
        stat_val = 16'($urandom);
        for (int k = 0; k < PW; k++) d[k] = seq ? 16'(k) : (16'($urandom) & 16'h7FFF);
        case (op)
            3'd0: begin
                pw(1, 0); pw(2, 0); pw(3, 16'h9E9E); pr(3); pr(1); pr(2);
                last_id = idcode; last_stat = stat_val;
                exp_res.push_back({1'b0, stat_val, idcode});
            end
            3'd1: begin
                pw(1, addr[15:0]); pw(2, addr[31:16]); pw(3, 16'hDEDE); pr(3);
                last_stat = stat_val;
                exp_res.push_back({1'b0, stat_val, last_id});
            end
            3'd2: begin
                pw(0, 16'h8000);
                for (int k = 0; k < PW; k++) pw(0, d[k]);
                pw(1, addr[15:0]); pw(2, addr[31:16]); pw(3, 16'h0302); pr(3);
                if (stop_at < 0) ref_flash[addr] = d;
                last_stat = stat_val;
                exp_res.push_back({1'b0, stat_val, last_id});
            end
            3'd3: begin
                pw(0, 16'h8000); pw(1, addr[15:0]); pw(2, addr[31:16]); pw(3, 16'h0203); pr(3);
                for (int k = 0; k < PW; k++) begin
                    pr(0);
                    exp_rd.push_back(ref_flash.exists(addr) ? ref_flash[addr][k] : 16'hFFFF);
                end
                last_stat = stat_val;
                exp_res.push_back({1'b0, stat_val, last_id});
            end
            3'd4: begin
                pw(1, 16'h6533); pw(2, 16'h4279); pw(3, 16'h93FE); pr(3);
                pw(1, 0); pw(2, 0); pw(3, 16'hFFFF); pr(3);
                last_stat = stat_val;
                exp_res.push_back({1'b1, stat_val, last_id});
            end
            default: exp_res.push_back({1'b1, last_stat, last_id});
        endcase
        while (!op_ready_o && n < 20000) begin @(posedge clk); #1; n++; end
        check("op_ready_wait", op_ready_o, 1);
        op_i = op; addr_i = addr; op_valid_i = 1'b1;
        @(posedge clk); #1;
        op_valid_i = 1'b0;
        if (op > 3'd4) check("illegal_next_cycle", {done_o, err_o}, 2'b11);
        if (op == 3'd2) begin
            n = 0;
            while (i < PW && n < 5000) begin
                if (i == stop_at) return;
                if ((seq && i == 50 && n < 60) || $urandom_range(0, 7) == 0) begin
                    wdat_valid_i = 1'b0;
                    repeat ((seq && i == 50) ? 2 : 1) @(posedge clk);
                    #1;
                end
                wdat_valid_i = 1'b1; wdat_i = d[i];
                @(negedge clk); rd = wdat_ready_o;
                @(posedge clk); #1;
                if (rd) i++;
                n++;
            end
            wdat_valid_i = 1'b0;
            check("prog_words_taken", i, PW);
        end
        n = 0;
        while (!done_o && n < 20000) begin @(posedge clk); #1; n++; end
        check("done_seen", done_o, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #1;
        check("reset_outputs", {op_ready_o, done_o, err_o, wdat_ready_o, rdat_valid_o, bl_en_o, bl_wr_o},
              7'b1000000);
        check("reset_values", {status_o, id_o, rdat_o, bl_adr_o, bl_dat_o}, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        run_op(3'd0, 32'h0, 1'b0, -1);
        run_op(3'd2, 32'h0001_0000, 1'b1, -1);
        run_op(3'd3, 32'h0001_0000, 1'b0, -1);
        run_op(3'd1, 32'h0002_0000, 1'b0, -1);
        run_op(3'd4, 32'h0, 1'b0, -1);
        run_op(3'd6, 32'h0, 1'b0, -1);
        // reset in the middle of a page fill
        run_op(3'd2, 32'h0003_0000, 1'b0, 100);
        rst_n = 1'b0;
        #1;
        check("midfill_reset_outputs", {op_ready_o, done_o, err_o, wdat_ready_o, rdat_valid_o, bl_en_o},
              6'b100000);
        check("midfill_reset_values", {status_o, id_o}, 0);
        wdat_valid_i = 1'b0;
        exp_bus.delete(); exp_res.delete(); exp_rd.delete();
        last_stat = 16'd0; last_id = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(3'd2, 32'h0003_0000, 1'b0, -1);
        run_op(3'd3, 32'h0003_0000, 1'b0, -1);
        for (int k = 0; k < 8; k++)
            run_op(3'($urandom_range(0, 7)), 32'h0001_0000 * $urandom_range(1, 3), 1'b0, -1);
        repeat (5) @(posedge clk);
        check("bus_queue_empty", exp_bus.size(), 0);
        check("result_queue_empty", exp_res.size(), 0);
        check("rdat_queue_empty", exp_rd.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/spi_bootload_seq.md
Name: spi_bootload_seq

Overview:
Command sequencer in front of spi_bootload's 4-register port (adr 0 = page FIFO, 1/2 = address lo/hi, 3 = command/status).
- Accepts one high-level flash op at a time and emits the exact register write/read sequence.
- Streams page data in and out, and reports the status word, IDCODE and errors.
- Sits between the board control interface and spi_bootload; it is the only master of the spi_bootload port.

Parameters:
- PAGE_WORDS, 256, 16-bit words per page transfer.
- CMD_ID, 16'h9E9E, command word for read-ID.
- CMD_PROG, 16'h0302, command word for page program.
- CMD_READ, 16'h0203, command word for page read.
- CMD_ERASE, 16'hDEDE, command word for sector erase.
- CMD_UNLOCK, 16'h93FE, command word for ICAP unlock.
- CMD_REBOOT, 16'hFFFF, command word for reboot.
- UNLOCK_KEY, 32'h42796533, ICAP unlock key, written as adr1 = [15:0], adr2 = [31:16].
- FIFO_RST, 16'h8000, adr0 write value that resets the page FIFO.
- TIMEOUT, 2000000, maximum clk cycles from a read's en pulse to bl_valid_i.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- op_i  in  3  opcode: 0 ID, 1 ERASE, 2 PROG, 3 READ, 4 REBOOT; 5-7 illegal.
- addr_i  in  32  flash address.
- op_valid_i  in  1  op request.
- op_ready_o  out  1  high only in IDLE; op, addr and operands latch on valid&ready.
- wdat_i  in  16  program page data.
- wdat_valid_i  in  1  program data valid.
- wdat_ready_o  out  1  program data accepted.
- rdat_o  out  16  read page data.
- rdat_valid_o  out  1  read data valid.
- rdat_ready_i  in  1  read data accepted.
- done_o  out  1  one-cycle pulse when an op completes.
- err_o  out  1  valid with done_o: timeout or illegal op.
- status_o  out  16  last adr3 read value; held until the next op's adr3 read.
- id_o  out  32  IDCODE; held until the next ID op.
- bl_adr_o  out  2  to spi_bootload adr_i.
- bl_dat_o  out  16  to spi_bootload dat_i.
- bl_en_o  out  1  to spi_bootload en_i.
- bl_wr_o  out  1  to spi_bootload wr_i.
- bl_dat_i  in  16  from spi_bootload dat_o.
- bl_valid_i  in  1  from spi_bootload dat_valid_o.

Behaviour:
Reset:
- All outputs 0 except op_ready_o = 1.
- FSM goes to IDLE and the timeout counter clears.
- Reset mid-op abandons the sequence immediately; no recovery writes are issued.

Access primitives:
- Write: bl_en_o = bl_wr_o = 1 for exactly one cycle with bl_adr_o/bl_dat_o valid. It completes that cycle, so the next access may start on the following cycle.
- Read: bl_en_o = 1, bl_wr_o = 0 for one cycle, then wait for bl_valid_i; capture bl_dat_i in that cycle. bl_en_o must never be high while a read is outstanding.
- Timeout: counter starts on the read's en cycle. If TIMEOUT elapses, abort the op and pulse done_o with err_o = 1.

Sequences (W = write adr,val; R = read adr):
- ID: W1,0; W2,0; W3,CMD_ID; R3 -> status_o; R1 -> id_o[15:0]; R2 -> id_o[31:16].
- ERASE: W1,addr[15:0]; W2,addr[31:16]; W3,CMD_ERASE; R3.
- PROG: W0,FIFO_RST; then PAGE_WORDS x W0,wdat_i; then W1; W2; W3,CMD_PROG; R3.
  - One word per cycle while wdat_valid_i is high; wdat_ready_o = wdat_valid_i only in the FILL state.
  - A gap stalls FILL indefinitely and never times out.
- READ: W0,FIFO_RST; W1; W2; W3,CMD_READ; R3; then PAGE_WORDS x R0.
  - Each R0 result is presented on rdat_o with rdat_valid_o, held until rdat_ready_i.
  - The next R0 is issued on the cycle after acceptance.
- REBOOT: W1,KEY[15:0]; W2,KEY[31:16]; W3,CMD_UNLOCK; R3; W1,0; W2,0; W3,CMD_REBOOT; R3. The final R3 timeout is reported normally.

Other rules:
- Illegal op: done_o and err_o pulse the cycle after acceptance, with no bus activity.
- done_o fires the cycle after the final capture; FSM returns to IDLE in the same cycle.
- Word counter is 9 bits and saturates at PAGE_WORDS; it must not wrap.
- FSM states: IDLE, FRST, FILL, WA1, WA2, WCMD, RSTAT, RID_LO, RID_HI, DRAIN, ULOCK, DONE. Each read state has an issue/wait phase handled by the access sub-module.

Decomposition:
- Package spi_bootload_pkg: op encodings, register address constants (FIFO=0, ADRLO=1, ADRHI=2, CMD=3), FSM state typedef.
- Sub-module spi_bootload_access: a single-access engine with request, done and timeout, owning the bl_* pins and the timeout counter.

Test Plan:
- ID op against the N25Q model → bus trace W1,0 W2,0 W3,9E9E R3 R1 R2; done_o = 1, err_o = 0, id_o matches the model IDCODE.
- PROG addr 0x00010000 with data 0..255 (one 2-cycle wdat_valid gap) → 8000 written first, 256 adr0 writes in order, W2 = 0001, W3 = 0302, done_o pulses once.
- READ addr 0x00010000, rdat_ready_i toggling 50% → 256 words 0..255 delivered in order, no drops or duplicates; bl_en_o never high while rdat_valid_o is unaccepted.
- ERASE then REBOOT → W3 = DEDE; unlock writes 6533/4279/93FE; final R3 with bl_valid_i held low for TIMEOUT = 100 → done_o with err_o = 1.
- op_i = 6 → done_o and err_o on the next cycle, zero bl_en_o pulses.
- rst_n_i asserted mid-FILL at word 100 → outputs return to reset values immediately; a following PROG completes normally.
